demux_dispatch_ctrl: RTL and testbench
======================================

// Module: demux_dispatch_ctrl
// PURPOSE
//  Sequencing controller for the 1-to-8 demux datapath. Accepts a stream of beats over a
//  valid/ready handshake and dispatches each beat to one of 8 sink channels. Drives the
//  3-bit demux select and a one-hot per-channel valid, and waits for the selected sink's ready.
//  Destination is either taken from the beat (addressed mode) or chosen round-robin over the
//  enabled channels. Sits between a single producer and the demux tree / 8 consumers.
// PARAMETERS
//  DW      8   data width of a beat
//  CNT_W   8   width of the saturating drop counter
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  mode       in   1      0 = addressed (use in_dest), 1 = round-robin
//  ch_enable  in   8      per-channel enable mask; bit k enables channel k
//  in_valid   in   1      producer beat valid
//  in_ready   out  1      controller can accept a beat this cycle
//  in_data    in   DW     producer beat payload
//  in_dest    in   3      destination channel (addressed mode only)
//  out_sel    out  3      demux select = index of the channel holding the beat
//  out_valid  out  8      one-hot valid; bit out_sel set while a beat is held, else 0
//  out_data   out  DW     held payload (demux input)
//  out_ready  in   8      per-channel sink ready
//  drop_cnt   out  CNT_W  beats dropped (addressed to a disabled channel), saturating
// BEHAVIOUR
//  - Reset: out_valid=0, out_sel=0, out_data=0, drop_cnt=0, rr_ptr=0, state=EMPTY.
//    in_ready is combinational and evaluates to 1 during and after reset whenever the accept
//    conditions below hold (with mode=0, or mode=1 and ch_enable!=0). Reset mid-operation
//    discards any held beat with no delivery.
//  - One-entry output register, two states: EMPTY, FULL.
//  - Accept = in_valid & in_ready. fire = FULL & out_ready[out_sel].
//  - in_ready = (EMPTY | fire) & !(mode & ch_enable==0); full throughput, one beat/cycle.
//  - Latency: an accepted beat appears on out_valid/out_sel/out_data the next cycle.
//  - Addressed mode: dest = in_dest. If ch_enable[in_dest]=0, the beat is accepted and dropped.
//    The register does not load, drop_cnt += 1 saturating at all-ones, and the state follows
//    fire (FULL->EMPTY on fire, else unchanged).
//  - Round-robin mode: dest = first enabled channel at or after rr_ptr (modulo 8). On accept,
//    rr_ptr <= dest+1 (wraps 7->0). If no channel is enabled, in_ready=0.
//  - FULL holds out_sel/out_data stable until fire. There is no timeout and no re-routing.
//  - A ch_enable change while FULL does not cancel the held beat; it is still delivered.
//  - A mode change takes effect on the next accept only.
//  - Simultaneous fire and accept: the new beat loads in the same edge and state stays FULL.
//  - FSM: EMPTY --accept&!drop--> FULL. FULL --fire&!(accept&!drop)--> EMPTY.
//    FULL --fire&accept&!drop--> FULL (reload). Any rst -> EMPTY.
// STRUCTURE
//  - Shared package: N_CH=8, SEL_W=3, mode encodings (MODE_ADDR=0, MODE_RR=1), state encodings.
//  - Sub-module rr_pick8: combinational rotate-priority find-first. Inputs: 8-bit mask and
//    3-bit start pointer. Outputs: 3-bit index and any_found.
//  - Remainder: the state register, output register, rr_ptr, and the drop counter.
// TESTING
//  1. mode=0, ch_enable=FF, beat data=A5 dest=5, all out_ready=1 -> next cycle out_sel=5,
//     out_valid=0010_0000, out_data=A5; EMPTY one cycle later.
//  2. Backpressure: dest=3, out_ready[3]=0 for 4 cycles -> out_valid=0000_1000 held 4+ cycles,
//     data stable, in_ready=0. Release -> fire, and an already-waiting beat loads the same edge.
//  3. mode=1, ch_enable=1010_0101, 5 back-to-back beats, sinks ready -> out_sel 0,2,5,7,0;
//     one beat per cycle.
//  4. mode=0, ch_enable=FE, 3 beats to dest 0 -> no out_valid; drop_cnt=3. Force 255 drops ->
//     drop_cnt saturates at FF.
//  5. mode=1, ch_enable=00, in_valid=1 -> in_ready=0, out_valid=0. Set enable=40 -> next beat
//     goes to out_sel=6.
//  6. Beat held on channel 2, out_ready=0, assert rst one cycle -> out_valid=0, drop_cnt=0,
//     next RR beat goes to channel 0.

Source files
------------

// File: rtl/demux_dispatch_ctrl_pkg.sv
// Shared constants, mode/state encodings and helpers for the 1-to-8 dispatch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_dispatch_ctrl_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_RR   = 1'b1
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // One-hot channel vector with only bit `sel` set.
  function automatic logic [N_CH-1:0] sel2onehot(input logic [SEL_W-1:0] sel);
    logic [N_CH-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_dispatch_ctrl_if.sv
// Producer-side beat handshake plus the 8-channel demux/sink handshake.
// Latency: n/a (wires only).
// Backpressure: in_ready from the controller, out_ready per sink.
interface demux_dispatch_ctrl_if #(
  parameter int DW = 8
);
  import demux_dispatch_ctrl_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [SEL_W-1:0] in_dest;
  logic [SEL_W-1:0] out_sel;
  logic [N_CH-1:0]  out_valid;
  logic [DW-1:0]    out_data;
  logic [N_CH-1:0]  out_ready;

  // Producer + sinks side
  modport master (
    output in_valid, in_data, in_dest, out_ready,
    input  in_ready, out_sel, out_valid, out_data
  );

  // Controller side
  modport slave (
    input  in_valid, in_data, in_dest, out_ready,
    output in_ready, out_sel, out_valid, out_data
  );

endinterface

// File: rtl/demux_dispatch_ctrl_rr_pick8.sv
// Rotating-priority find-first: first set bit of mask at or after start, modulo 8.
// Latency: purely combinational.
// Backpressure: none; any_found=0 when the mask is empty.
module rr_pick8
  import demux_dispatch_ctrl_pkg::*;
(
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             any_found
);

  logic [SEL_W-1:0] cand;

  // Walk the channels starting at `start`; the first enabled one wins.
  always_comb begin
    idx       = '0;
    any_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = start + SEL_W'(i);
      if (!any_found && mask[cand]) begin
        idx       = cand;
        any_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Dispatches producer beats to one of 8 sinks (addressed or round-robin) via a one-entry output register.
// Latency: accepted beat visible on out_valid/out_sel/out_data one cycle after accept.
// Backpressure: in_ready drops while the held beat's sink is not ready, or in RR mode with no enabled channel.
module demux_dispatch_ctrl
  import demux_dispatch_ctrl_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 8
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic [N_CH-1:0]              ch_enable,
  demux_dispatch_ctrl_if.slave         bus,
  output logic [CNT_W-1:0]             drop_cnt
);

  state_e           state;
  logic [SEL_W-1:0] sel_q;
  logic [DW-1:0]    data_q;
  logic [N_CH-1:0]  vld_q;
  logic [SEL_W-1:0] rr_ptr;
  logic [CNT_W-1:0] drop_q;

  logic [SEL_W-1:0] rr_idx;
  logic             rr_found;
  logic             full;
  logic             fire;
  logic             rr_blocked;
  logic             in_ready_c;
  logic             accept;
  logic             drop;
  logic             load;
  logic [SEL_W-1:0] dest;

  rr_pick8 u_pick (
    .mask      (ch_enable),
    .start     (rr_ptr),
    .idx       (rr_idx),
    .any_found (rr_found)
  );

  assign full       = (state == ST_FULL);
  assign fire       = full & bus.out_ready[sel_q];
  // In RR mode an empty enable mask leaves nowhere to send a beat, so stall the producer.
  assign rr_blocked = (mode == MODE_RR) & ~rr_found;
  assign in_ready_c = (~full | fire) & ~rr_blocked;
  assign accept     = bus.in_valid & in_ready_c;
  assign dest       = (mode == MODE_RR) ? rr_idx : bus.in_dest;
  // Only addressed beats can target a disabled channel; RR always picks an enabled one.
  assign drop       = accept & (mode == MODE_ADDR) & ~ch_enable[bus.in_dest];
  assign load       = accept & ~drop;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign drop_cnt      = drop_q;

  // Holding-register FSM with registered outputs, RR pointer and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      sel_q  <= '0;
      data_q <= '0;
      vld_q  <= '0;
      rr_ptr <= '0;
      drop_q <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (load) begin
            state  <= ST_FULL;
            sel_q  <= dest;
            data_q <= bus.in_data;
            vld_q  <= sel2onehot(dest);
          end
        end
        ST_FULL: begin
          // A fire with a same-cycle load reloads in place and stays FULL.
          if (load) begin
            sel_q  <= dest;
            data_q <= bus.in_data;
            vld_q  <= sel2onehot(dest);
          end else if (fire) begin
            state <= ST_EMPTY;
            vld_q <= '0;
          end
        end
        default: begin
          state <= ST_EMPTY;
          vld_q <= '0;
        end
      endcase

      if (drop && (drop_q != {CNT_W{1'b1}})) begin
        drop_q <= drop_q + CNT_W'(1);
      end

      if (accept && (mode == MODE_RR)) begin
        rr_ptr <= rr_idx + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
module tb_demux_dispatch_ctrl;
  import demux_dispatch_ctrl_pkg::*;

  localparam int DW    = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mode = 1'b0;
  logic [7:0]       ch_enable = 8'hFF;
  logic [CNT_W-1:0] drop_cnt;

  demux_dispatch_ctrl_if #(.DW(DW)) bus ();

  demux_dispatch_ctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .ch_enable (ch_enable),
    .bus       (bus.slave),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: at most one beat in flight, described by a queue of channel/data pairs.
  typedef struct { int ch; int data; } beat_t;
  beat_t held_q[$];
  int    m_rr    = 0;
  int    m_drops = 0;
  int    acc_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // First enabled channel at or after ptr, going around the 8 channels; -1 if none.
  function automatic int rr_dest(input int ptr, input logic [7:0] en);
    for (int k = 0; k < 8; k++) begin
      if (en[(ptr + k) % 8]) return (ptr + k) % 8;
    end
    return -1;
  endfunction

  // One clock: apply inputs, compare DUT against the model mid-cycle, then advance the model.
  task automatic cycle(input bit v, input int dest, input int data, input logic [7:0] rdy);
    bit fire, rdy_exp, acc, drop;
    int d;
    bus.in_valid  = v;
    bus.in_dest   = dest[2:0];
    bus.in_data   = data[7:0];
    bus.out_ready = rdy;
    @(negedge clk);
    fire    = (held_q.size() != 0) && rdy[held_q[0].ch];
    rdy_exp = ((held_q.size() == 0) || fire) && !(mode && ch_enable == 8'h00);
    chk("in_ready", bus.in_ready, rdy_exp);
    chk("out_valid", bus.out_valid, (held_q.size() != 0) ? (32'd1 << held_q[0].ch) : 32'd0);
    if (held_q.size() != 0) begin
      chk("out_sel", bus.out_sel, held_q[0].ch);
      chk("out_data", bus.out_data, held_q[0].data);
    end
    chk("drop_cnt", drop_cnt, m_drops);
    if (rst) begin
      held_q.delete();
      m_rr    = 0;
      m_drops = 0;
    end else begin
      acc  = v && rdy_exp;
      d    = mode ? rr_dest(m_rr, ch_enable) : dest;
      drop = acc && !mode && !ch_enable[dest % 8];
      if (fire) void'(held_q.pop_front());
      if (acc && !drop) begin
        held_q.push_back('{ch: d, data: data % 256});
        acc_log.push_back(d);
      end
      if (drop && m_drops < 255) m_drops++;
      if (acc && mode) m_rr = (d + 1) % 8;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_dest   = '0;
    bus.in_data   = '0;
    bus.out_ready = '0;

    // Reset
    @(posedge clk);
    #1;
    cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sel", bus.out_sel, 0);
    chk("rst_out_data", bus.out_data, 0);
    rst = 1'b0;

    // Addressed single beat
    mode = MODE_ADDR; ch_enable = 8'hFF;
    cycle(1, 5, 8'hA5, 8'hFF);
    chk("t1_sel", bus.out_sel, 5);
    chk("t1_vld", bus.out_valid, 8'h20);
    chk("t1_data", bus.out_data, 8'hA5);
    cycle(0, 0, 0, 8'hFF);
    chk("t1_empty", bus.out_valid, 0);

    // Backpressure on channel 3 with a waiting beat, then release with reload on the same edge
    cycle(1, 3, 8'h3C, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 6, 8'h77, 8'hF7);
      chk("t2_hold_vld", bus.out_valid, 8'h08);
      chk("t2_hold_data", bus.out_data, 8'h3C);
    end
    cycle(1, 6, 8'h77, 8'hFF);
    chk("t2_reload_vld", bus.out_valid, 8'h40);
    chk("t2_reload_data", bus.out_data, 8'h77);

    // Round-robin over A5
    mode = MODE_RR; ch_enable = 8'hA5;
    cycle(0, 0, 0, 8'hFF);
    acc_log.delete();
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'h10 + i, 8'hFF);
    chk("t3_count", acc_log.size(), 5);
    if (acc_log.size() == 5) begin
      chk("t3_sel0", acc_log[0], 0);
      chk("t3_sel1", acc_log[1], 2);
      chk("t3_sel2", acc_log[2], 5);
      chk("t3_sel3", acc_log[3], 7);
      chk("t3_sel4", acc_log[4], 0);
    end

    // Drops to a disabled channel, then saturation
    mode = MODE_ADDR; ch_enable = 8'hFE;
    for (int i = 0; i < 3; i++) cycle(1, 0, 8'h55, 8'hFF);
    chk("t4_drops", drop_cnt, 3);
    chk("t4_no_vld", bus.out_valid, 0);
    for (int i = 0; i < 260; i++) cycle(1, 0, i, 8'hFF);
    chk("t4_sat", drop_cnt, 8'hFF);

    // RR with nothing enabled stalls; enabling channel 6 releases it
    mode = MODE_RR; ch_enable = 8'h00;
    cycle(1, 0, 8'h99, 8'hFF);
    chk("t5_stall_rdy", bus.in_ready, 0);
    chk("t5_stall_vld", bus.out_valid, 0);
    ch_enable = 8'h40;
    cycle(1, 0, 8'h99, 8'hFF);
    chk("t5_sel", bus.out_sel, 6);

    // Reset while holding a beat on channel 2
    mode = MODE_ADDR; ch_enable = 8'hFF;
    cycle(1, 2, 8'h11, 8'hFF);
    cycle(0, 0, 0, 8'h00);
    rst = 1'b1;
    cycle(0, 0, 0, 8'h00);
    rst = 1'b0;
    chk("t6_vld", bus.out_valid, 0);
    chk("t6_drops", drop_cnt, 0);
    mode = MODE_RR;
    cycle(1, 0, 8'h22, 8'hFF);
    chk("t6_sel", bus.out_sel, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      if ($urandom_range(0, 19) == 0)
        ch_enable = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 255),
            8'($urandom) | 8'($urandom));
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
